mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single cache controller port (address/wdata/read-enable/write-enable in, rdata/ready out) between two pipeline requesters: instruction fetch (port I) and data memory stage (port D).
- Registered grant FSM. One transaction outstanding at a time.
- Requester ready is low while the requester waits, so it doubles as that stage's freeze.
- Includes a watchdog that flags a downstream port that never completes.

Parameters:
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports
- TIMEOUT_CYCLES, 1023, max cycles a granted transaction may wait for downstream ready before timeout_err sets; counter width $clog2(TIMEOUT_CYCLES+1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_rd_en  in  1  port I read request
- i_address  in  ADDR_WIDTH  port I address
- i_rdata  out  DATA_WIDTH  port I read data
- i_ready  out  1  port I ready (low = freeze)
- d_rd_en  in  1  port D read request
- d_wr_en  in  1  port D write request
- d_address  in  ADDR_WIDTH  port D address
- d_wdata  in  DATA_WIDTH  port D write data
- d_rdata  out  DATA_WIDTH  port D read data
- d_ready  out  1  port D ready (low = freeze)
- mem_address  out  ADDR_WIDTH  to cache controller
- mem_wdata  out  DATA_WIDTH  to cache controller
- mem_r_en  out  1  to cache controller
- mem_w_en  out  1  to cache controller
- mem_rdata  in  DATA_WIDTH  from cache controller
- mem_ready  in  1  from cache controller; high = current access complete
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, grant cleared, watchdog=0, timeout_err=0, last_owner=I.
  - mem_r_en=mem_w_en=0; mem_address=mem_wdata=0.
  - i_rdata=d_rdata=0.
  - i_ready=~i_rd_en and d_ready=~(d_rd_en|d_wr_en), evaluated combinationally.
- Reset asserted mid-transaction aborts the transaction; mem enables drop in the same instant.
- Requester contract:
  - Raise enable with address/wdata stable.
  - Hold until own ready=1 is sampled on a rising edge.
  - A requester with no enable sees ready=1.
- d_rd_en and d_wr_en together: treated as a write; mem_r_en=0.
- States:
  - IDLE: mem enables 0, both requester readies 0 if requesting.
    - Only I pending -> GRANT_I.
    - Only D pending -> GRANT_D.
    - Both pending -> GRANT_D (fixed priority, D over I).
    - None -> IDLE.
  - GRANT_I: mem_* driven from port I (mem_w_en=0); i_ready=mem_ready; i_rdata=mem_rdata when mem_ready=1, else 0.
    - mem_ready=1 -> IDLE.
    - i_rd_en dropped (protocol violation) -> IDLE without completing.
  - GRANT_D: mem_* driven from port D; d_ready=mem_ready; d_rdata=mem_rdata when mem_ready=1. Exits as for GRANT_I.
- The non-granted requester's ready stays 0 while it requests.
- Latency:
  - Minimum 2 cycles per access: one IDLE arbitration cycle, then a granted cycle on a cache hit.
  - A miss extends the granted cycles until mem_ready.
  - Back-to-back requests from the same port each pay the IDLE cycle.
- Watchdog:
  - Counter clears on entry to a GRANT state and increments each GRANT cycle with mem_ready=0.
  - On reaching TIMEOUT_CYCLES, timeout_err<=1 (sticky until reset); FSM keeps waiting, no forced abort.
  - Counter saturates, no wrap.
- last_owner updates on every GRANT->IDLE transition.
- rdata outputs are combinational passthrough, not held after completion.

Optional Feature:
- Macro: MEM_PORT_ARBITER_RR_EN.
- Defined: on simultaneous I and D requests in IDLE, grant the port that is not last_owner (round-robin). Single-port requests behave as without the macro.
- Undefined: fixed priority D over I. last_owner is still tracked but unused; port I may starve indefinitely.

Test Plan:
- Reset with i_rd_en=1, d_wr_en=1 held, rst=0 -> mem_r_en=mem_w_en=0, i_ready=0, d_ready=0, timeout_err=0; after release, GRANT_D first.
- I read 0x40, mem_ready tied 1, mem_rdata=0xDEADBEEF -> mem_r_en high exactly cycle 2; i_ready=1 and i_rdata=0xDEADBEEF in that cycle; total 2 cycles.
- I and D both request, D write 0x80/0x12345678 -> D served first (mem_w_en=1, mem_wdata=0x12345678), i_ready=0 throughout; I granted after D completes plus one IDLE cycle. With RR_EN and last_owner=D, I is served first.
- D read miss, mem_ready low 17 cycles then high -> d_ready=0 for 18 cycles total, then 1 for one cycle with correct rdata; timeout_err stays 0.
- TIMEOUT_CYCLES=8, mem_ready held 0 -> timeout_err rises after 8 granted cycles; stays 1 after mem_ready later completes; clears only on rst=0.
- rst pulsed low during GRANT_D miss -> mem_w_en/mem_r_en drop immediately; after release, the pending D request is re-arbitrated from IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch (I) and data (D) requesters onto a single cache controller port.
// Optional MEM_PORT_ARBITER_RR_EN: round-robin on simultaneous requests (default: fixed D-over-I).
module mem_port_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_rd_en,
   input  logic [ADDR_WIDTH-1:0] i_address,
   output logic [DATA_WIDTH-1:0] i_rdata,
   output logic                  i_ready,
   input  logic                  d_rd_en,
   input  logic                  d_wr_en,
   input  logic [ADDR_WIDTH-1:0] d_address,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  d_ready,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_r_en,
   output logic                  mem_w_en,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ready,
   output logic                  timeout_err
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] WD_MAX = CW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] wd_cnt_reg, wd_cnt_next;
   logic          timeout_err_reg, timeout_err_next;
   logic          last_owner_reg, last_owner_next;  // 1 = D owned the port last
   logic          d_req;
   logic          granted;

   assign d_req       = d_rd_en | d_wr_en;
   assign granted     = (state_reg == GRANT_I) || (state_reg == GRANT_D);
   assign timeout_err = timeout_err_reg;

`ifndef MEM_PORT_ARBITER_RR_EN
   logic unused_last_owner;
   assign unused_last_owner = last_owner_reg;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg       <= IDLE;
         wd_cnt_reg      <= '0;
         timeout_err_reg <= 1'b0;
         last_owner_reg  <= 1'b0;
      end else begin
         state_reg       <= state_next;
         wd_cnt_reg      <= wd_cnt_next;
         timeout_err_reg <= timeout_err_next;
         last_owner_reg  <= last_owner_next;
      end
   end

   // Watchdog is held at zero outside grants, so every grant starts counting from zero.
   always_comb begin
      wd_cnt_next      = wd_cnt_reg;
      timeout_err_next = timeout_err_reg;
      if (!granted)
         wd_cnt_next = '0;
      else if (!mem_ready && (wd_cnt_reg != WD_MAX))
         wd_cnt_next = wd_cnt_reg + CW'(1);
      if (granted && (wd_cnt_next == WD_MAX))
         timeout_err_next = 1'b1;
   end

   always_comb begin
      state_next      = state_reg;
      last_owner_next = last_owner_reg;
      mem_address     = '0;
      mem_wdata       = '0;
      mem_r_en        = 1'b0;
      mem_w_en        = 1'b0;
      i_rdata         = '0;
      d_rdata         = '0;
      i_ready         = ~i_rd_en;
      d_ready         = ~d_req;
      case (state_reg)
         IDLE: begin
`ifdef MEM_PORT_ARBITER_RR_EN
            if (d_req && !(i_rd_en && last_owner_reg))
               state_next = GRANT_D;
            else if (i_rd_en)
               state_next = GRANT_I;
`else
            if (d_req)
               state_next = GRANT_D;
            else if (i_rd_en)
               state_next = GRANT_I;
`endif
         end
         GRANT_I: begin
            mem_address = i_address;
            mem_r_en    = i_rd_en;
            i_ready     = mem_ready;
            i_rdata     = mem_ready ? mem_rdata : '0;
            if (mem_ready || !i_rd_en) begin
               state_next      = IDLE;
               last_owner_next = 1'b0;
            end
         end
         GRANT_D: begin
            mem_address = d_address;
            mem_wdata   = d_wdata;
            mem_w_en    = d_wr_en;
            mem_r_en    = d_rd_en & ~d_wr_en;
            d_ready     = mem_ready;
            d_rdata     = mem_ready ? mem_rdata : '0;
            if (mem_ready || !d_req) begin
               state_next      = IDLE;
               last_owner_next = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end
endmodule
